hub_mgmt_scheduler: RTL and testbench
=====================================

// Module: hub_mgmt_scheduler
// PURPOSE
//  Shares the hub's Wishbone management bus (the per-port PHY mux) between an external
//  host master and an internal link poller. Host cycles get priority. Between host cycles,
//  the poller sweeps every port's status register (reg 1, BMSR) once per POLL_INTERVAL.
//  It exports per-port link/error flags for LEDs and a port-enable manager. Sits between
//  the host bus and the hub's wb_* management port.
// PARAMETERS
//  PORT_COUNT     4       number of PHY ports; address width is PORT_COUNT + 5
//  POLL_INTERVAL  125000  clk cycles between sweep starts (1 ms at 125 MHz), >= 2
//  STATUS_REG     5'd1    register polled on each port
//  LINK_BIT       2       bit of STATUS_REG giving link status
//  TIMEOUT        15      cycles to wait for m_ack/m_err before a poll is abandoned
// PORTS
//  clk            in   1               single clock, all logic
//  rst_n          in   1               asynchronous, active-low reset
//  h_cyc,h_stb    in   1               host Wishbone master strobes
//  h_we           in   1               host write enable
//  h_addr         in   PORT_COUNT+5    host address {one-hot port select, reg}
//  h_data_write   in   16              host write data
//  h_ack,h_err    out  1               host termination
//  h_data_read    out  16              host read data
//  m_cyc,m_stb    out  1               to hub management bus
//  m_we           out  1
//  m_addr         out  PORT_COUNT+5
//  m_data_write   out  16
//  m_ack,m_err    in   1               from hub management bus
//  m_data_read    in   16
//  link_up        out  PORT_COUNT      last polled link bit per port
//  poll_err       out  PORT_COUNT      last poll of port errored or timed out
//  sweep_done     out  1               1-cycle pulse after the last port of a sweep
// BEHAVIOUR
//  Reset: all outputs 0; link_up=0, poll_err=0, port index p=0, interval counter=POLL_INTERVAL-1,
//   sweep_pending=1 (first sweep starts right after reset), state IDLE. An async reset during
//   any state drops m_cyc/m_stb immediately.
//  Interval counter: free-running down-counter. At 0 it reloads POLL_INTERVAL-1 and sets
//   sweep_pending. If already pending, the requests merge (no queueing).
//  States:
//   IDLE -> HOST if h_cyc&&h_stb (host wins ties); else -> POLL if sweep_pending; else stay.
//   HOST: m_* = h_* combinationally; h_ack=m_ack, h_err=m_err, h_data_read=m_data_read.
//     Stays while h_cyc=1 (multi-beat blocks are allowed). On h_cyc=0 -> IDLE next cycle.
//   POLL: registered m_cyc=m_stb=1, m_we=0, m_addr={1<<p, STATUS_REG}, m_data_write=0;
//     timeout counter loads TIMEOUT on entry and decrements each cycle.
//     m_err (also m_err&&m_ack together): poll_err[p]=1, link_up[p]=0 -> GAP.
//     m_ack alone: link_up[p]=m_data_read[LINK_BIT], poll_err[p]=0 -> GAP.
//     Timeout reaches 0 with no ack/err: poll_err[p]=1, link_up[p]=0 -> GAP.
//   GAP: m_cyc=m_stb=0 for exactly 1 cycle. If p==PORT_COUNT-1: p=0, clear sweep_pending,
//     pulse sweep_done; else p=p+1. -> IDLE. This means the host can take the bus
//     between any two port polls.
//  Outside HOST: h_ack=h_err=0 and the host is stalled (Wishbone wait states). Host strobes
//   raised mid-POLL are not forwarded and are serviced after GAP.
//  Worst-case host wait = TIMEOUT+2 cycles. Poll latency per port = ack latency + 2 cycles.
//  link_up/poll_err change only in the POLL exit cycle. They never glitch in HOST.
// TESTING
//  1. After reset, slave acks in 1 cycle with data 16'h0004 for ports 0,2 and 16'h0000 for 1,3
//     -> addresses 9'h021,041,081,101 in order; link_up=4'b0101; sweep_done pulses once.
//  2. Host read of 9'h045 asserted the same cycle sweep_pending sets -> host served first,
//     h_data_read=m_data_read; the poll starts only after h_cyc drops.
//  3. Port 3 never acks -> m_cyc drops after 15 cycles; poll_err=4'b1000, link_up[3]=0;
//     the host, stalled in the meantime, is granted within 17 cycles.
//  4. m_ack and m_err asserted together on port 1 -> poll_err[1]=1, link_up[1]=0.
//  5. POLL_INTERVAL=20, slow slave so a sweep takes >20 cycles -> exactly one follow-on
//     sweep, no lost or duplicated ports, p wraps 3->0.
//  6. rst_n low mid-POLL -> m_cyc=0 the same cycle; outputs zero; sweep restarts at port 0.

Source files
------------

// File: rtl/hub_mgmt_scheduler.sv
// hub_mgmt_scheduler
// Arbitrates the hub's Wishbone management bus between an external host master
// and an internal link poller. Host cycles win; between them the poller reads
// each port's status register once per poll interval and publishes per-port
// link and error flags.
module hub_mgmt_scheduler #(
  parameter int         PORT_COUNT    = 4,
  parameter int         POLL_INTERVAL = 125000,
  parameter logic [4:0] STATUS_REG    = 5'd1,
  parameter int         LINK_BIT      = 2,
  parameter int         TIMEOUT       = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // host master side
  input  logic                  h_cyc,
  input  logic                  h_stb,
  input  logic                  h_we,
  input  logic [PORT_COUNT+4:0] h_addr,
  input  logic [15:0]           h_data_write,
  output logic                  h_ack,
  output logic                  h_err,
  output logic [15:0]           h_data_read,
  // hub management bus side
  output logic                  m_cyc,
  output logic                  m_stb,
  output logic                  m_we,
  output logic [PORT_COUNT+4:0] m_addr,
  output logic [15:0]           m_data_write,
  input  logic                  m_ack,
  input  logic                  m_err,
  input  logic [15:0]           m_data_read,
  // status
  output logic [PORT_COUNT-1:0] link_up,
  output logic [PORT_COUNT-1:0] poll_err,
  output logic                  sweep_done
);

  localparam int PW = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
  localparam int CW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOST,
    ST_POLL,
    ST_GAP
  } state_t;

  state_t                state, state_next;
  logic [PW-1:0]         port_idx;
  logic [CW-1:0]         interval_cnt;
  logic                  sweep_pending;
  logic [TW-1:0]         tmo_cnt;
  logic                  interval_tick;
  logic                  last_port;
  logic                  tmo_expire;
  logic [PORT_COUNT-1:0] port_onehot;

  assign interval_tick = (interval_cnt == '0);
  assign last_port     = (port_idx == PW'(PORT_COUNT - 1));
  assign tmo_expire    = (tmo_cnt == TW'(1));
  assign port_onehot   = PORT_COUNT'(1) << port_idx;

  // State register; reset parks the bus in IDLE so m_cyc drops asynchronously.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state decision: host wins ties, a poll ends on ack, err or timeout.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (h_cyc && h_stb)     state_next = ST_HOST;
        else if (sweep_pending) state_next = ST_POLL;
      end
      ST_HOST: if (!h_cyc) state_next = ST_IDLE;
      ST_POLL: if (m_err || m_ack || tmo_expire) state_next = ST_GAP;
      ST_GAP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus steering: host passes straight through in HOST, poller drives in POLL.
  always_comb begin
    m_cyc        = 1'b0;
    m_stb        = 1'b0;
    m_we         = 1'b0;
    m_addr       = '0;
    m_data_write = '0;
    h_ack        = 1'b0;
    h_err        = 1'b0;
    h_data_read  = '0;
    unique case (state)
      ST_HOST: begin
        m_cyc        = h_cyc;
        m_stb        = h_stb;
        m_we         = h_we;
        m_addr       = h_addr;
        m_data_write = h_data_write;
        h_ack        = m_ack;
        h_err        = m_err;
        h_data_read  = m_data_read;
      end
      ST_POLL: begin
        m_cyc  = 1'b1;
        m_stb  = 1'b1;
        m_addr = {port_onehot, STATUS_REG};
      end
      default: ;
    endcase
  end

  assign sweep_done = (state == ST_GAP) && last_port;

  // Free-running interval counter that raises a sweep request on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             interval_cnt <= CW'(POLL_INTERVAL - 1);
    else if (interval_tick) interval_cnt <= CW'(POLL_INTERVAL - 1);
    else                    interval_cnt <= interval_cnt - CW'(1);
  end

  // Sweep request flag; a new tick wins over the end-of-sweep clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             sweep_pending <= 1'b1;
    else if (interval_tick)                 sweep_pending <= 1'b1;
    else if ((state == ST_GAP) && last_port) sweep_pending <= 1'b0;
  end

  // Port pointer advances in the gap after each poll and wraps after the last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                port_idx <= '0;
    else if (state == ST_GAP)  port_idx <= last_port ? '0 : port_idx + PW'(1);
  end

  // Poll timeout: held at TIMEOUT outside POLL, counts down while polling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_cnt <= TW'(TIMEOUT);
    else if (state == ST_POLL) tmo_cnt <= tmo_cnt - TW'(1);
    else                       tmo_cnt <= TW'(TIMEOUT);
  end

  // Status flags update only in the cycle a poll terminates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_up  <= '0;
      poll_err <= '0;
    end else if (state == ST_POLL) begin
      if (m_err) begin
        link_up[port_idx]  <= 1'b0;
        poll_err[port_idx] <= 1'b1;
      end else if (m_ack) begin
        link_up[port_idx]  <= m_data_read[LINK_BIT];
        poll_err[port_idx] <= 1'b0;
      end else if (tmo_expire) begin
        link_up[port_idx]  <= 1'b0;
        poll_err[port_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hub_mgmt_scheduler.sv
// tb_hub_mgmt_scheduler
// Directed bench: a Wishbone slave model answers polls with per-port data and
// host accesses with 16'hA000|addr; each scenario task checks its own results.
module tb_hub_mgmt_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        h_cyc, h_stb, h_we;
  logic [8:0]  h_addr;
  logic [15:0] h_data_write;
  logic        h_ack, h_err;
  logic [15:0] h_data_read;
  logic        m_cyc, m_stb, m_we;
  logic [8:0]  m_addr;
  logic [15:0] m_data_write;
  logic        m_ack, m_err;
  logic [15:0] m_data_read;
  logic [3:0]  link_up, poll_err;
  logic        sweep_done;

  int n_checks = 0;
  int n_fail   = 0;

  hub_mgmt_scheduler #(
    .PORT_COUNT(4), .POLL_INTERVAL(20), .STATUS_REG(5'd1), .LINK_BIT(2), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .h_cyc(h_cyc), .h_stb(h_stb), .h_we(h_we), .h_addr(h_addr),
    .h_data_write(h_data_write), .h_ack(h_ack), .h_err(h_err), .h_data_read(h_data_read),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
    .m_data_write(m_data_write), .m_ack(m_ack), .m_err(m_err), .m_data_read(m_data_read),
    .link_up(link_up), .poll_err(poll_err), .sweep_done(sweep_done)
  );

  always #4 clk = ~clk;

  // Slave model configuration
  logic [3:0]  nak_mask, err_mask, both_mask;
  int          lat;
  logic [15:0] port_data [4];

  logic        s_ack, s_err;
  logic [15:0] s_data;
  int          wcnt;

  assign m_ack       = s_ack;
  assign m_err       = s_err;
  assign m_data_read = s_data;

  function automatic int onehot_idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic logic [8:0] poll_addr_of(input int i);
    logic [3:0] oh;
    oh = 4'b0001 << i;
    return {oh, 5'd1};
  endfunction

  // Slave: responds lat edges after seeing a strobe, single-cycle ack/err.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack <= 1'b0; s_err <= 1'b0; s_data <= '0; wcnt <= 0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      if (m_cyc && m_stb && !s_ack && !s_err) begin
        if (m_addr[4:0] == 5'd1 && |(m_addr[8:5] & nak_mask)) begin
          wcnt <= 0;
        end else if (wcnt + 1 >= lat) begin
          wcnt <= 0;
          if (m_addr[4:0] == 5'd1) begin
            s_data <= port_data[onehot_idx(m_addr[8:5])];
            if (|(m_addr[8:5] & both_mask))     begin s_ack <= 1'b1; s_err <= 1'b1; end
            else if (|(m_addr[8:5] & err_mask)) s_err <= 1'b1;
            else                                s_ack <= 1'b1;
          end else begin
            s_data <= 16'hA000 | {7'd0, m_addr};
            s_ack  <= 1'b1;
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  // Bus monitor: logs each poll start, poll lengths and sweep_done pulses.
  logic [8:0] poll_log [16];
  int         poll_n, done_cnt, cur_len, last_len;
  logic       prev_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      poll_n <= 0; done_cnt <= 0; cur_len <= 0; last_len <= 0; prev_cyc <= 1'b0;
    end else begin
      if (sweep_done) done_cnt <= done_cnt + 1;
      if (m_cyc && !prev_cyc && m_addr[4:0] == 5'd1 && !m_we) begin
        if (poll_n < 16) poll_log[poll_n] <= m_addr;
        poll_n <= poll_n + 1;
      end
      if (m_cyc) cur_len <= cur_len + 1;
      else if (prev_cyc) begin
        last_len <= cur_len;
        cur_len  <= 0;
      end
      prev_cyc <= m_cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0; h_addr = '0; h_data_write = '0;
    nak_mask = '0; err_mask = '0; both_mask = '0; lat = 1;
    port_data[0] = 16'h0004; port_data[1] = 16'h0000;
    port_data[2] = 16'h0004; port_data[3] = 16'h0000;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) tick();
  endtask

  task automatic wait_polls(input int target, input int budget);
    for (int i = 0; i < budget && poll_n < target; i++) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    h_cyc = 1'b1; h_stb = 1'b1; h_we = 1'b1; h_addr = 9'h045; h_data_write = 16'h1234;
    nak_mask = '0; err_mask = '0; both_mask = '0; lat = 1;
    repeat (2) tick();
    n_checks++;
    if ({m_cyc, m_stb, m_we, m_addr, m_data_write} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got %b/%b/%b/%h/%h required all zero", m_cyc, m_stb, m_we, m_addr, m_data_write);
    end
    n_checks++;
    if ({h_ack, h_err, h_data_read, link_up, poll_err, sweep_done} !== '0) begin
      n_fail++;
      $display("FAIL reset_status: ack=%b err=%b rd=%h link=%b perr=%b done=%b required all zero",
               h_ack, h_err, h_data_read, link_up, poll_err, sweep_done);
    end
  endtask

  task automatic test_sweep();
    do_reset();
    wait_done(1, 100);
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL sweep_done_seen: got %0d required 1", done_cnt);
    end
    n_checks++;
    if (poll_n !== 4) begin
      n_fail++; $display("FAIL sweep_poll_count: got %0d required 4", poll_n);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (poll_log[i] !== poll_addr_of(i)) begin
        n_fail++; $display("FAIL sweep_addr%0d: got %h required %h", i, poll_log[i], poll_addr_of(i));
      end
    end
    n_checks++;
    if (link_up !== 4'b0101 || poll_err !== 4'b0000) begin
      n_fail++; $display("FAIL sweep_flags: link=%b perr=%b required 0101/0000", link_up, poll_err);
    end
    n_checks++;
    if (last_len !== 2) begin
      n_fail++; $display("FAIL sweep_poll_len: got %0d required 2", last_len);
    end
    repeat (3) tick();
    n_checks++;
    if (done_cnt !== 1) begin
      n_fail++; $display("FAIL sweep_done_single: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_host_priority();
    do_reset();
    repeat (20) tick();  // after edge 20: sweep 1 finished, new request just raised
    n_checks++;
    if (done_cnt !== 1 || m_cyc !== 1'b0) begin
      n_fail++; $display("FAIL prio_idle: done=%0d m_cyc=%b required 1/0", done_cnt, m_cyc);
    end
    h_cyc = 1'b1; h_stb = 1'b1; h_we = 1'b0; h_addr = 9'h045;
    tick();
    n_checks++;
    if (m_cyc !== 1'b1 || m_addr !== 9'h045 || m_we !== 1'b0) begin
      n_fail++; $display("FAIL prio_host_first: m_cyc=%b addr=%h we=%b required 1/045/0", m_cyc, m_addr, m_we);
    end
    tick();
    n_checks++;
    if (h_ack !== 1'b1 || h_data_read !== 16'hA045) begin
      n_fail++; $display("FAIL prio_read: ack=%b data=%h required 1/a045", h_ack, h_data_read);
    end
    tick();
    h_we = 1'b1; h_addr = 9'h046; h_data_write = 16'hBEEF;
    #1;
    n_checks++;
    if (m_we !== 1'b1 || m_addr !== 9'h046 || m_data_write !== 16'hBEEF || h_ack !== 1'b0) begin
      n_fail++; $display("FAIL b2b_write_fwd: we=%b addr=%h wd=%h ack=%b required 1/046/beef/0",
                         m_we, m_addr, m_data_write, h_ack);
    end
    tick();
    n_checks++;
    if (h_ack !== 1'b1) begin
      n_fail++; $display("FAIL b2b_write_ack: got %b required 1", h_ack);
    end
    tick();
    h_cyc = 1'b0; h_stb = 1'b0; h_we = 1'b0;
    tick();
    n_checks++;
    if (m_cyc !== 1'b0 || poll_n !== 4 || h_ack !== 1'b0) begin
      n_fail++; $display("FAIL prio_release: m_cyc=%b polls=%0d ack=%b required 0/4/0", m_cyc, poll_n, h_ack);
    end
    tick();
    n_checks++;
    if (m_cyc !== 1'b1 || m_addr !== 9'h021) begin
      n_fail++; $display("FAIL prio_poll_after: m_cyc=%b addr=%h required 1/021", m_cyc, m_addr);
    end
  endtask

  task automatic test_timeout();
    int waited;
    bit granted;
    do_reset();
    port_data[1] = 16'h0004; port_data[3] = 16'h0004;
    wait_done(1, 100);
    n_checks++;
    if (link_up !== 4'b1111) begin
      n_fail++; $display("FAIL tmo_pre_link: got %b required 1111", link_up);
    end
    nak_mask = 4'b1000;
    wait_polls(8, 200);
    n_checks++;
    if (poll_n !== 8 || poll_log[7] !== 9'h101) begin
      n_fail++; $display("FAIL tmo_port3_start: polls=%0d addr=%h required 8/101", poll_n, poll_log[7]);
    end
    h_cyc = 1'b1; h_stb = 1'b1; h_we = 1'b0; h_addr = 9'h045;
    waited = 0;
    granted = 1'b0;
    for (int i = 0; i < 40 && !granted; i++) begin
      tick();
      waited++;
      if (m_cyc && m_addr == 9'h045) granted = 1'b1;
    end
    n_checks++;
    if (!granted || waited !== 17) begin
      n_fail++; $display("FAIL tmo_host_wait: granted=%b cycles=%0d required 1/17", granted, waited);
    end
    n_checks++;
    if (last_len !== 15) begin
      n_fail++; $display("FAIL tmo_poll_len: got %0d required 15", last_len);
    end
    n_checks++;
    if (poll_err !== 4'b1000 || link_up !== 4'b0111) begin
      n_fail++; $display("FAIL tmo_flags: perr=%b link=%b required 1000/0111", poll_err, link_up);
    end
    tick();
    n_checks++;
    if (h_ack !== 1'b1 || h_data_read !== 16'hA045) begin
      n_fail++; $display("FAIL tmo_host_read: ack=%b data=%h required 1/a045", h_ack, h_data_read);
    end
    h_cyc = 1'b0; h_stb = 1'b0;
    tick();
  endtask

  task automatic test_ack_err();
    do_reset();
    port_data[1] = 16'h0004; port_data[3] = 16'h0004;
    both_mask = 4'b0010;
    err_mask  = 4'b0100;
    wait_done(1, 100);
    n_checks++;
    if (poll_n !== 4) begin
      n_fail++; $display("FAIL err_poll_count: got %0d required 4", poll_n);
    end
    n_checks++;
    if (poll_err !== 4'b0110 || link_up !== 4'b1001) begin
      n_fail++; $display("FAIL err_flags: perr=%b link=%b required 0110/1001", poll_err, link_up);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    lat = 5;
    wait_done(2, 400);
    n_checks++;
    if (done_cnt !== 2 || poll_n !== 8) begin
      n_fail++; $display("FAIL wrap_counts: done=%0d polls=%0d required 2/8", done_cnt, poll_n);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (poll_log[i] !== poll_addr_of(i % 4)) begin
        n_fail++; $display("FAIL wrap_addr%0d: got %h required %h", i, poll_log[i], poll_addr_of(i % 4));
      end
    end
    n_checks++;
    if (last_len !== 6 || link_up !== 4'b0101) begin
      n_fail++; $display("FAIL wrap_len_link: len=%0d link=%b required 6/0101", last_len, link_up);
    end
  endtask

  task automatic test_reset_mid_poll();
    do_reset();
    wait_polls(2, 100);
    n_checks++;
    if (poll_n !== 2 || m_cyc !== 1'b1 || link_up !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_pre: polls=%0d m_cyc=%b link=%b required 2/1/0001", poll_n, m_cyc, link_up);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_cyc !== 1'b0 || m_stb !== 1'b0 || m_addr !== 9'h000 || link_up !== 4'b0000 || poll_err !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_async: m_cyc=%b m_stb=%b addr=%h link=%b perr=%b required 0/0/000/0000/0000",
                         m_cyc, m_stb, m_addr, link_up, poll_err);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    wait_polls(1, 20);
    n_checks++;
    if (poll_n !== 1 || poll_log[0] !== 9'h021) begin
      n_fail++; $display("FAIL midrst_restart: polls=%0d addr=%h required 1/021", poll_n, poll_log[0]);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_host_priority();
    test_timeout();
    test_ack_err();
    test_wrap();
    test_reset_mid_poll();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
